// File: rtl/tx_ltssm_substate_if.sv
// tx_ltssm_substate_if: bundle between the main LTSSM / PIPE / framing side and the Tx substate engine
//   master: drives substateTx, linkNumberTx, rxTs2Ok, rxIdleOk, PhyStatus, RxStatus, osDone;
//           observes TxDetectRx, TxElecIdle, osValid, osType, osLinkNumber, finishTx, gotoTx
//   slave : the substate engine (opposite directions)
interface tx_ltssm_substate_if;
    logic [3:0] substateTx;
    logic [7:0] linkNumberTx;
    logic       rxTs2Ok;
    logic       rxIdleOk;
    logic       PhyStatus;
    logic [2:0] RxStatus;
    logic       osDone;
    logic       TxDetectRx;
    logic       TxElecIdle;
    logic       osValid;
    logic [1:0] osType;
    logic [7:0] osLinkNumber;
    logic       finishTx;
    logic [3:0] gotoTx;

    modport master (
        output substateTx, linkNumberTx, rxTs2Ok, rxIdleOk, PhyStatus, RxStatus, osDone,
        input  TxDetectRx, TxElecIdle, osValid, osType, osLinkNumber, finishTx, gotoTx
    );

    modport slave (
        input  substateTx, linkNumberTx, rxTs2Ok, rxIdleOk, PhyStatus, RxStatus, osDone,
        output TxDetectRx, TxElecIdle, osValid, osType, osLinkNumber, finishTx, gotoTx
    );
endinterface

// File: rtl/tx_ltssm_substate.sv
// tx_ltssm_substate: Tx-side LTSSM substate engine answering the main LTSSM with finishTx/gotoTx
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : slave view of tx_ltssm_substate_if (substate command, Rx qualifiers, PIPE sideband,
//           ordered-set request to framing, completion/next-substate report)
module tx_ltssm_substate #(
    parameter int DETECT_QUIET_CYCLES = 12,
    parameter int TIMEOUT_CYCLES      = 24,
    parameter int POLL_TS1_MIN        = 1024,
    parameter int TS2_MIN             = 16,
    parameter int IDLE_MIN            = 16
) (
    input logic               clk,
    input logic               reset,
    tx_ltssm_substate_if.slave bus
);
    localparam logic [3:0] DETECT_QUIET          = 4'd0;
    localparam logic [3:0] DETECT_ACTIVE         = 4'd1;
    localparam logic [3:0] POLLING_ACTIVE        = 4'd2;
    localparam logic [3:0] POLLING_CONFIGURATION = 4'd3;
    localparam logic [3:0] CONFIGURATION_IDLE    = 4'd9;
    localparam logic [3:0] L0                    = 4'd10;

    localparam logic [7:0]  PAD          = 8'hF7;
    localparam logic [10:0] SET_MAX      = '1;
    localparam logic [10:0] TS1_LAST     = 11'(POLL_TS1_MIN - 1);
    localparam logic [10:0] TS2_LAST     = 11'(TS2_MIN - 1);
    localparam logic [10:0] IDLE_LAST    = 11'(IDLE_MIN - 1);
    localparam logic [15:0] QUIET_LAST   = 16'(DETECT_QUIET_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [3:0]  lastSub;
    logic [10:0] setCount;
    logic [15:0] cycleCount;
    logic        okLatched;
    logic        phyDone;

    logic        entry;
    logic        isIdle;
    logic        okNow;
    logic [10:0] setLast;
    logic        countSet;
    logic        success;
    logic        timeout;

    always_comb begin
        entry    = bus.substateTx != lastSub;
        isIdle   = bus.substateTx == CONFIGURATION_IDLE;
        // the Rx qualifier is sticky for the rest of the substate once seen
        okNow    = okLatched || (isIdle ? bus.rxIdleOk : bus.rxTs2Ok);
        setLast  = isIdle ? IDLE_LAST : TS2_LAST;
        // osValid is already low once finishTx is up, so this also blocks counting after exit
        countSet = bus.osDone && bus.osValid;
        success  = countSet && okNow && setCount == setLast;
        timeout  = cycleCount == TIMEOUT_LAST;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastSub          <= DETECT_QUIET;
            setCount         <= '0;
            cycleCount       <= '0;
            okLatched        <= 1'b0;
            phyDone          <= 1'b0;
            bus.TxDetectRx   <= 1'b0;
            bus.TxElecIdle   <= 1'b1;
            bus.osValid      <= 1'b0;
            bus.osType       <= 2'd0;
            bus.osLinkNumber <= PAD;
            bus.finishTx     <= 1'b0;
            bus.gotoTx       <= 4'd0;
        end else begin
            lastSub <= bus.substateTx;
            if (entry) begin
                // abandon whatever was in flight; the new substate acts from the next cycle
                setCount         <= '0;
                cycleCount       <= '0;
                okLatched        <= 1'b0;
                phyDone          <= 1'b0;
                bus.TxDetectRx   <= 1'b0;
                bus.osValid      <= 1'b0;
                bus.osType       <= 2'd0;
                bus.osLinkNumber <= PAD;
                bus.finishTx     <= 1'b0;
                bus.gotoTx       <= 4'd0;
            end else if (!bus.finishTx) begin
                case (bus.substateTx)
                    DETECT_QUIET: begin
                        bus.TxElecIdle <= 1'b1;
                        bus.osValid    <= 1'b0;
                        cycleCount     <= cycleCount + 1'b1;
                        if (cycleCount == QUIET_LAST) begin
                            bus.finishTx <= 1'b1;
                            bus.gotoTx   <= 4'd1;
                        end
                    end
                    DETECT_ACTIVE: begin
                        bus.TxElecIdle <= 1'b1;
                        if (phyDone) begin
                            bus.finishTx <= 1'b1;
                        end else if (bus.TxDetectRx && bus.PhyStatus) begin
                            bus.TxDetectRx <= 1'b0;
                            phyDone        <= 1'b1;
                            bus.gotoTx     <= bus.RxStatus == 3'b011 ? 4'd2 : 4'd0;
                        end else begin
                            bus.TxDetectRx <= 1'b1;
                        end
                    end
                    POLLING_ACTIVE: begin
                        bus.TxElecIdle <= 1'b0;
                        bus.osType     <= 2'd1;
                        bus.osValid    <= 1'b1;
                        if (countSet) begin
                            setCount <= setCount == SET_MAX ? setCount : setCount + 1'b1;
                            if (setCount == TS1_LAST) begin
                                bus.finishTx <= 1'b1;
                                bus.gotoTx   <= 4'd3;
                                bus.osValid  <= 1'b0;
                            end
                        end
                    end
                    POLLING_CONFIGURATION, CONFIGURATION_IDLE: begin
                        bus.TxElecIdle   <= 1'b0;
                        bus.osType       <= isIdle ? 2'd3 : 2'd2;
                        bus.osValid      <= 1'b1;
                        bus.osLinkNumber <= isIdle ? bus.linkNumberTx : PAD;
                        okLatched        <= okNow;
                        cycleCount       <= cycleCount + 1'b1;
                        if (countSet && okNow)
                            setCount <= setCount + 1'b1;
                        // success is tested first so it wins a same-cycle tie with the timeout
                        if (success || timeout) begin
                            bus.finishTx <= 1'b1;
                            bus.osValid  <= 1'b0;
                            bus.gotoTx   <= success ? (isIdle ? 4'd10 : 4'd4) : 4'd0;
                        end
                    end
                    L0: begin
                        bus.TxElecIdle <= 1'b0;
                        bus.osValid    <= 1'b0;
                    end
                    default: begin
                        bus.TxElecIdle <= 1'b0;
                        bus.osValid    <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tx_ltssm_substate.sv
// tb_tx_ltssm_substate: self-checking bench for tx_ltssm_substate
module tb_tx_ltssm_substate;
    localparam int QUIET   = 12;
    localparam int TIMEOUT = 24;
    localparam int TS1_MIN = 1024;
    localparam int TS2_MIN = 16;
    localparam int IDLE_MIN = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tx_ltssm_substate_if bus ();
    tx_ltssm_substate dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad = 0;
    bit stDone[1:30];
    bit stOk[1:30];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_det"}, bus.TxDetectRx, 0);
        check({tag, "_eidle"}, bus.TxElecIdle, 1);
        check({tag, "_valid"}, bus.osValid, 0);
        check({tag, "_type"}, bus.osType, 0);
        check({tag, "_link"}, bus.osLinkNumber, 8'hF7);
        check({tag, "_fin"}, bus.finishTx, 0);
        check({tag, "_goto"}, bus.gotoTx, 0);
    endtask

    task automatic visitL0();
        bus.substateTx = 4'd10;
        tick();
        tick();
        check("l0_eidle", bus.TxElecIdle, 0);
        check("l0_valid", bus.osValid, 0);
        check("l0_fin", bus.finishTx, 0);
    endtask

    task automatic runDetect(input logic [2:0] rs, input int w);
        bus.substateTx = 4'd1;
        tick();
        check("da_entry_fin", bus.finishTx, 0);
        check("da_entry_det", bus.TxDetectRx, 0);
        tick();
        check("da_det_on", bus.TxDetectRx, 1);
        check("da_eidle", bus.TxElecIdle, 1);
        repeat (w) begin
            tick();
            check("da_det_hold", bus.TxDetectRx, 1);
        end
        bus.PhyStatus = 1'b1;
        bus.RxStatus = rs;
        tick();
        bus.PhyStatus = 1'b0;
        bus.RxStatus = 3'b000;
        check("da_det_off", bus.TxDetectRx, 0);
        check("da_fin_early", bus.finishTx, 0);
        tick();
        check("da_fin", bus.finishTx, 1);
        check("da_goto", bus.gotoTx, rs == 3'b011 ? 2 : 0);
        tick();
        check("da_hold_fin", bus.finishTx, 1);
        check("da_hold_det", bus.TxDetectRx, 0);
    endtask

    task automatic pulse(input string tag, input bit expFin);
        repeat ($urandom_range(0, 2)) tick();
        bus.osDone = 1'b1;
        tick();
        bus.osDone = 1'b0;
        check(tag, bus.finishTx, expFin);
    endtask

    task automatic clearSt();
        for (int k = 1; k <= 30; k++) begin
            stDone[k] = 1'b0;
            stOk[k] = 1'b0;
        end
    endtask

    // reference: the MIN-th osDone seen at/after the first Rx qualifier wins,
    // otherwise the substate times out after TIMEOUT cycles
    task automatic runCfg(input logic [3:0] sub, input logic [7:0] link);
        int fin;
        int n;
        int need;
        bit seen;
        logic [3:0] goal;
        need = sub == 4'd9 ? IDLE_MIN : TS2_MIN;
        fin = TIMEOUT;
        goal = 4'd0;
        n = 0;
        seen = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            seen = seen | stOk[k];
            if (stDone[k] && seen) n++;
            if (n == need) begin
                fin = k;
                goal = sub == 4'd9 ? 4'd10 : 4'd4;
                break;
            end
        end
        visitL0();
        bus.linkNumberTx = link;
        bus.substateTx = sub;
        tick();
        check("cfg_entry_fin", bus.finishTx, 0);
        for (int k = 1; k <= 30; k++) begin
            bus.osDone = stDone[k];
            if (sub == 4'd9) bus.rxIdleOk = stOk[k];
            else bus.rxTs2Ok = stOk[k];
            tick();
            check("cfg_fin", bus.finishTx, k >= fin);
            check("cfg_valid", bus.osValid, k < fin);
            check("cfg_type", bus.osType, sub == 4'd9 ? 3 : 2);
            check("cfg_link", bus.osLinkNumber, sub == 4'd9 ? link : 8'hF7);
            if (k >= fin) check("cfg_goto", bus.gotoTx, goal);
        end
        bus.osDone = 1'b0;
        bus.rxTs2Ok = 1'b0;
        bus.rxIdleOk = 1'b0;
    endtask

    task automatic randomCfg(input logic [3:0] sub);
        int okStart;
        clearSt();
        okStart = $urandom_range(1, 12);
        for (int k = 2; k <= 30; k++) begin
            stDone[k] = $urandom_range(0, 3) != 0;
            stOk[k] = (k >= okStart) && ($urandom_range(0, 1) == 1);
        end
        runCfg(sub, 8'($urandom_range(0, 255)));
    endtask

    initial begin
        bus.substateTx = 4'd0;
        bus.linkNumberTx = 8'h00;
        bus.rxTs2Ok = 1'b0;
        bus.rxIdleOk = 1'b0;
        bus.PhyStatus = 1'b0;
        bus.RxStatus = 3'b000;
        bus.osDone = 1'b0;
        tick();
        tick();
        checkResetValues("rst");
        reset = 1'b0;

        // detectQuiet straight out of reset
        for (int k = 1; k <= QUIET + 2; k++) begin
            tick();
            check("dq_fin", bus.finishTx, k >= QUIET);
            check("dq_eidle", bus.TxElecIdle, 1);
            check("dq_valid", bus.osValid, 0);
            if (k >= QUIET) check("dq_goto", bus.gotoTx, 1);
        end

        // detectActive: receiver present, absent, random status
        runDetect(3'b011, $urandom_range(0, 4));
        visitL0();
        runDetect(3'b000, $urandom_range(0, 4));
        visitL0();
        runDetect(3'($urandom_range(0, 7)), $urandom_range(0, 4));

        // pollingActive abandoned after 500 TS1, then detectQuiet from scratch
        visitL0();
        bus.substateTx = 4'd2;
        tick();
        tick();
        check("pa_valid", bus.osValid, 1);
        check("pa_type", bus.osType, 1);
        check("pa_eidle", bus.TxElecIdle, 0);
        for (int i = 0; i < 500; i++) pulse("pa_part_fin", 1'b0);
        bus.substateTx = 4'd0;
        tick();
        check("abort_fin", bus.finishTx, 0);
        check("abort_valid", bus.osValid, 0);
        for (int k = 1; k <= QUIET; k++) begin
            tick();
            check("abort_dq_fin", bus.finishTx, k >= QUIET);
            check("abort_dq_eidle", bus.TxElecIdle, 1);
        end

        // pollingActive full run: counter must restart from zero
        bus.substateTx = 4'd2;
        tick();
        tick();
        for (int i = 1; i < TS1_MIN; i++) begin
            pulse("pa_fin_early", 1'b0);
            if (i % 256 == 0) check("pa_type_run", bus.osType, 1);
        end
        pulse("pa_fin", 1'b1);
        check("pa_goto", bus.gotoTx, 3);
        check("pa_valid_drop", bus.osValid, 0);
        pulse("pa_hold_fin", 1'b1);
        check("pa_hold_goto", bus.gotoTx, 3);

        // pollingConfiguration: 5 early sets ignored, one-cycle rxTs2Ok latches, 16 counted
        clearSt();
        for (int k = 2; k <= 6; k++) stDone[k] = 1'b1;
        stOk[7] = 1'b1;
        for (int k = 7; k <= 22; k++) stDone[k] = 1'b1;
        runCfg(4'd3, 8'h00);

        // pollingConfiguration timeout with rxTs2Ok never seen
        clearSt();
        for (int k = 2; k <= 30; k++) stDone[k] = 1'b1;
        runCfg(4'd3, 8'h00);

        // configurationIdle: 16th IDLE lands on the timeout cycle, success wins
        clearSt();
        for (int k = 1; k <= 30; k++) stOk[k] = 1'b1;
        for (int k = 9; k <= 24; k++) stDone[k] = 1'b1;
        runCfg(4'd9, 8'h05);

        // configurationIdle: plain success well before the timeout
        clearSt();
        for (int k = 1; k <= 30; k++) stOk[k] = 1'b1;
        for (int k = 2; k <= 17; k++) stDone[k] = 1'b1;
        runCfg(4'd9, 8'h05);

        for (int r = 0; r < 6; r++) begin
            randomCfg(4'd3);
            randomCfg(4'd9);
        end

        // asynchronous reset in the middle of detectActive
        visitL0();
        bus.substateTx = 4'd1;
        tick();
        tick();
        check("ra_det_on", bus.TxDetectRx, 1);
        #2 reset = 1'b1;
        #1;
        checkResetValues("async_rst");
        tick();
        reset = 1'b0;
        tick();
        check("ra_reentry_det", bus.TxDetectRx, 0);
        tick();
        check("ra_redet_on", bus.TxDetectRx, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tx_ltssm_substate.md
Name: tx_ltssm_substate

Overview:
- Transmit-side LTSSM substate engine. It is the partner that the main LTSSM drives through substateTx and that answers it on finishTx and gotoTx.
- For the commanded substate it performs Tx-side actions:
  - receiver detection on PIPE
  - electrical idle control
  - TS1/TS2/IDLE ordered-set requests to the framing block
- It reports completion and the next substate back to the main LTSSM.
- It sits between the main LTSSM and the Tx ordered-set/framing logic, with a sideband to the PIPE PHY.

Parameters:
- DETECT_QUIET_CYCLES, 12, cycles spent in detectQuiet before requesting detectActive.
- TIMEOUT_CYCLES, 24, substate timeout in cycles for pollingConfiguration and configurationIdle.
- POLL_TS1_MIN, 1024, number of TS1 ordered sets sent in pollingActive before exit.
- TS2_MIN, 16, number of TS2 sent in pollingConfiguration after the first rxTs2Ok.
- IDLE_MIN, 16, number of IDLE sets sent in configurationIdle after the first rxIdleOk.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- substateTx  in  4  commanded substate; encoding 0 detectQuiet … 10 L0
- linkNumberTx  in  8  link number for TS fields in configurationIdle
- rxTs2Ok  in  1  level; Rx has seen 8 consecutive TS2
- rxIdleOk  in  1  level; Rx has seen 8 consecutive IDLE
- PhyStatus  in  1  PIPE completion pulse
- RxStatus  in  3  PIPE status; 3'b011 = receiver present
- osDone  in  1  one-cycle pulse; the current requested ordered set has been fully sent
- TxDetectRx  out  1  PIPE receiver-detect request
- TxElecIdle  out  1  PIPE electrical idle
- osValid  out  1  ordered-set request valid
- osType  out  2  0 none, 1 TS1, 2 TS2, 3 IDLE
- osLinkNumber  out  8  link field; 8'hF7 (PAD) except in configurationIdle
- finishTx  out  1  substate work complete (level)
- gotoTx  out  4  next substate; meaningful only while finishTx=1

Behaviour:
- Reset values (async, active-high): TxDetectRx=0, TxElecIdle=1, osValid=0, osType=0, osLinkNumber=8'hF7, finishTx=0, gotoTx=0; all counters 0; internal last-substate register=0.
- Entry detection:
  - substateTx is registered each cycle.
  - When substateTx differs from the registered value: finishTx clears, all counters clear, and the new substate's action starts on the following cycle.
- Exit hold: once finishTx=1, finishTx and gotoTx hold until substateTx changes. No further osDone counting occurs while finishTx=1.
- detectQuiet:
  - TxElecIdle=1, osValid=0.
  - Counter runs to DETECT_QUIET_CYCLES-1, then finishTx=1, gotoTx=1.
- detectActive:
  - TxElecIdle=1. TxDetectRx asserts one cycle after entry and holds until a PhyStatus pulse.
  - On PhyStatus: TxDetectRx=0 in the same clock update. finishTx=1 on the next cycle.
  - gotoTx=2 if RxStatus==3'b011 sampled with PhyStatus, else gotoTx=0.
- pollingActive:
  - TxElecIdle=0, osValid=1, osType=1.
  - Each osDone increments a TS1 counter (11 bits, saturating).
  - When the count reaches POLL_TS1_MIN: finishTx=1, gotoTx=3, osValid=0.
- pollingConfiguration:
  - osType=2, osValid=1.
  - The TS2 counter counts osDone only while rxTs2Ok=1, or once it has latched high (rxTs2Ok is sticky per substate).
  - Count reaching TS2_MIN with the latch set: finishTx=1, gotoTx=4.
  - Timeout counter reaching TIMEOUT_CYCLES first: finishTx=1, gotoTx=0.
  - If both conditions occur in the same cycle, the success exit wins.
- configurationIdle:
  - osType=3, osValid=1, osLinkNumber=linkNumberTx.
  - Same counting and timeout scheme as pollingConfiguration, using rxIdleOk and IDLE_MIN.
  - Success: gotoTx=10. Timeout: gotoTx=0.
- L0: TxElecIdle=0, osValid=0, finishTx=0.
- Any other substate: osValid=0, TxElecIdle=0, finishTx=0, no timeout.
- osValid drops the same cycle finishTx rises. An osDone arriving in that cycle is ignored.
- A substate change mid-operation abandons the current action immediately, including deasserting TxDetectRx.
- Reset mid-operation returns all outputs to their reset values asynchronously.

Test Plan:
- Reset, then substateTx=0 -> TxElecIdle=1; finishTx rises exactly 12 cycles after entry with gotoTx=1.
- substateTx=1, PhyStatus pulse with RxStatus=3'b011 -> TxDetectRx 1→0, finishTx=1, gotoTx=2. Repeat with RxStatus=3'b000 -> gotoTx=0.
- substateTx=2, 1024 osDone pulses -> osType=1 throughout; finishTx=1, gotoTx=3 after the 1024th pulse, osValid=0.
- substateTx=3, 5 osDone pulses before rxTs2Ok, then rxTs2Ok=1 and 16 pulses -> only 16 counted; gotoTx=4. Repeat with rxTs2Ok held 0 -> gotoTx=0 at cycle 24.
- substateTx=9, linkNumberTx=8'h05 -> osLinkNumber=8'h05, osType=3; 16 osDone pulses with rxIdleOk=1 -> gotoTx=10. Success and timeout in the same cycle -> gotoTx=10.
- Change substateTx from 2 to 0 after 500 TS1, and separately assert reset mid-detectActive -> counters clear, TxDetectRx=0, finishTx=0 immediately.
